clk_div_gen: RTL and testbench
==============================

Name: clk_div_gen

Overview:
- Parametrised, runtime-programmable clock-enable generator; successor to the fixed-ratio clock divider used to feed flash-controller timing logic.
- Runs entirely in one clock domain and produces NCH independent channels.
- Each channel provides a one-cycle tick strobe and a registered square-wave enable, so downstream logic stays on clk instead of using derived clocks.
- Divisors are written over a simple write port, applied glitch-free at period boundaries, and all channels can be phase-aligned with a sync pulse.

Parameters:
- NCH, 4, number of channels (1..16).
- DIV_W, 20, divisor width; legal divisor range 1..2^DIV_W-1.
- SEL_W, 2, width of div_sel; must satisfy 2^SEL_W >= NCH.
- DEF_DIV, {20'd1000000,20'd24,20'd16,20'd2}, packed NCH*DIV_W reset divisors; channel 0 occupies the LSBs.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- ch_en, input, NCH, per-channel run enable.
- sync, input, 1, one-cycle pulse that restarts all enabled channels in phase.
- div_wr, input, 1, divisor write strobe.
- div_sel, input, SEL_W, target channel for write and read-back.
- div_val, input, DIV_W, divisor to write.
- div_ack, output, 1, one-cycle pulse: write accepted.
- div_err, output, 1, one-cycle pulse: write rejected.
- div_cur, output, DIV_W, active divisor of the div_sel channel (combinational mux).
- tick, output, NCH, one-cycle strobe at the start of each period.
- clk_out, output, NCH, registered 50%-style square wave.

Behaviour:
- Reset: rst is synchronous and active-high; clk is the only clock. While rst=1 at an edge:
  - all counters = 0;
  - active divisors = DEF_DIV;
  - pending flags cleared;
  - tick = 0, clk_out = 0, div_ack = 0, div_err = 0.
- Per channel, active divisor D:
  - Period = D cycles; counter runs 0..D-1, then wraps to 0.
  - The edge that loads counter=0 starts a period and registers tick=1 for exactly one cycle.
  - clk_out=1 while counter < ceil(D/2), else 0. D=2 gives 1 high/1 low; D=3 gives 2 high/1 low.
  - D=1: tick and clk_out remain 1 every cycle while enabled.
- Start: the first edge with rst=0 and ch_en[i]=1, after the channel was reset or disabled, starts a period (tick=1, clk_out=1 in that cycle).
- Disable: an edge with ch_en[i]=0 sets counter=0, tick=0, clk_out=0. There is no partial-period output after disable.
- Write handshake: sampled at an edge with div_wr=1.
  - Accepted when div_sel<NCH and div_val!=0: div_val goes into the channel's pending register, pending flag set; div_ack=1 in the following cycle.
  - Otherwise rejected: div_err=1 in the following cycle; no state changes.
  - div_wr may be asserted every cycle.
  - Repeated writes to a channel before the pending value is applied: last write wins.
- Divisor apply:
  - An enabled channel copies pending to active on the edge that starts its next period, so the new period uses the new D. The running period is never truncated or stretched.
  - A disabled channel applies pending on the next edge.
  - If a write and a period start coincide on the same edge, the write becomes pending and applies at the following boundary.
- sync: an edge with sync=1 makes every enabled channel start a new period on that edge (counter=0, tick=1, clk_out=1), applying any pending divisor first. Disabled channels are unaffected.
- Priority: rst > ch_en=0 > sync > normal count.
- Reset mid-period: everything returns to reset values on that edge; pending writes are discarded.
- div_cur reflects the active divisor only, not the pending one. Returns 0 when div_sel>=NCH.
- Counter arithmetic: DIV_W bits, unsigned; no overflow, since the counter never exceeds D-1.

Test Plan:
- Reset release, defaults, ch_en=4'b1111:
  - ch0 ticks every 2 cycles, clk_out 1/0 alternating;
  - ch1 ticks every 16 cycles, high 8/low 8;
  - ch2 ticks every 24 cycles;
  - ch3 ticks 1,000,000 cycles apart;
  - all channels tick on the first post-reset edge.
- Write ch1=5 mid-period (counter=3):
  - div_ack next cycle;
  - current 16-cycle period completes unchanged;
  - afterwards period 5, clk_out high 3/low 2;
  - div_cur for sel=1 changes only at that boundary.
- Invalid writes: div_val=0 or div_sel=4 with NCH=4 -> div_err pulse; divisors and outputs unchanged; no div_ack.
- Two writes to ch2 (7, then 9) before the boundary -> period becomes 9. D=1 write -> tick and clk_out held 1.
- sync pulse while ch0 and ch1 are at arbitrary phase -> both tick on the same edge, then keep their own periods. A channel with ch_en=0 produces no tick.
- Drop ch_en[1] mid-period, re-enable 10 cycles later -> tick/clk_out go 0 on the next edge, restart on the re-enable edge. rst asserted mid-period with a pending write -> DEF_DIV restored and pending discarded.

Source files
------------

// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
//
// Runtime-programmable clock-enable generator. Produces NCH independent
// channels on the single clk domain. Each channel emits a one-cycle tick at the
// start of every period and a registered square-wave enable (clk_out). The
// downstream logic therefore stays on clk and never uses a derived clock.
//
// Divisors are written through a small write port. A written value is held as
// "pending" and only becomes active on the edge that starts the channel's next
// period, so a running period is never cut short or stretched. A sync pulse
// restarts every enabled channel in phase.
//
// Ports
//   clk      : system clock, all logic on the rising edge
//   rst      : synchronous active-high reset
//   ch_en    : [NCH]   per-channel run enable
//   sync     : one-cycle pulse, restart all enabled channels in phase
//   div_wr   : divisor write strobe
//   div_sel  : [SEL_W] channel addressed for write and read-back
//   div_val  : [DIV_W] divisor to write (legal 1..2^DIV_W-1)
//   div_ack  : one-cycle pulse, previous-cycle write accepted
//   div_err  : one-cycle pulse, previous-cycle write rejected
//   div_cur  : [DIV_W] active divisor of the div_sel channel (0 if out of range)
//   tick     : [NCH]   one-cycle strobe at the start of each period
//   clk_out  : [NCH]   registered square wave, high for ceil(D/2) cycles
// -----------------------------------------------------------------------------
module clk_div_gen #(
  parameter int                    NCH     = 4,
  parameter int                    DIV_W   = 20,
  parameter int                    SEL_W   = 2,
  parameter logic [NCH*DIV_W-1:0]  DEF_DIV = {20'd1000000, 20'd24, 20'd16, 20'd2}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic [DIV_W-1:0] div_cur,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);

  // ---------------------------------------------------------------------------
  // Write port decode (shared by all channels)
  // ---------------------------------------------------------------------------
  logic sel_in_range;
  logic wr_ok;
  logic div_ack_q, div_ack_d;
  logic div_err_q, div_err_d;

  // div_sel may be wider than needed to address NCH channels, so addresses
  // at or above NCH are rejected rather than aliased.
  assign sel_in_range = (int'(div_sel) < NCH);
  assign wr_ok        = div_wr && sel_in_range && (div_val != '0);

  always_comb begin
    div_ack_d = wr_ok;
    div_err_d = div_wr && !wr_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_ack_q <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      div_ack_q <= div_ack_d;
      div_err_q <= div_err_d;
    end
  end

  assign div_ack = div_ack_q;
  assign div_err = div_err_q;

  // Active divisor of every channel, gathered for the read-back mux.
  logic [DIV_W-1:0] act_all [NCH];

  // ---------------------------------------------------------------------------
  // Per-channel divider
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DIV_W-1:0] cnt_q,  cnt_d;
    logic [DIV_W-1:0] act_q,  act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             run_q,  run_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;

    logic             wr_hit;
    logic             at_end;
    logic             start;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half_act;
    logic [DIV_W-1:0] next_div;

    assign wr_hit   = wr_ok && (div_sel == SEL_W'(gi));
    // Last count of the running period; the following edge starts a new one.
    assign at_end   = (cnt_q == (act_q - DIV_W'(1)));
    // A channel that was reset or disabled starts a period on its first
    // enabled edge; sync forces a start on all enabled channels.
    assign start    = !run_q || sync || at_end;
    assign cnt_inc  = cnt_q + DIV_W'(1);
    // ceil(D/2): number of high cycles in a period.
    assign half_act = (act_q >> 1) + {{(DIV_W-1){1'b0}}, act_q[0]};
    // The divisor a new period will use: a pending write wins.
    assign next_div = pend_vld_q ? pend_q : act_q;

    always_comb begin
      cnt_d      = cnt_q;
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      run_d      = run_q;
      tick_d     = 1'b0;
      clk_out_d  = 1'b0;

      if (!ch_en[gi]) begin
        // Idle channel: outputs low, counter parked, pending applied at once.
        cnt_d = '0;
        run_d = 1'b0;
        if (pend_vld_q) begin
          act_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else if (start) begin
        // Counter 0 is always below ceil(D/2) for D>=1, so clk_out is high.
        act_d      = next_div;
        pend_vld_d = 1'b0;
        cnt_d      = '0;
        run_d      = 1'b1;
        tick_d     = 1'b1;
        clk_out_d  = 1'b1;
      end else begin
        // cnt_q < D-1 here, so the increment cannot overflow.
        cnt_d     = cnt_inc;
        clk_out_d = (cnt_inc < half_act);
      end

      // A write on the same edge as a period start is captured after the
      // apply above, so it waits for the following boundary.
      if (wr_hit) begin
        pend_d     = div_val;
        pend_vld_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q      <= '0;
        act_q      <= DEF_DIV[gi*DIV_W +: DIV_W];
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
        run_q      <= 1'b0;
        tick_q     <= 1'b0;
        clk_out_q  <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_q      <= act_d;
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
        run_q      <= run_d;
        tick_q     <= tick_d;
        clk_out_q  <= clk_out_d;
      end
    end

    assign tick[gi]    = tick_q;
    assign clk_out[gi] = clk_out_q;
    assign act_all[gi] = act_q;
  end

  // ---------------------------------------------------------------------------
  // Read-back mux: active divisor only, 0 for an unused address.
  // ---------------------------------------------------------------------------
  always_comb begin
    div_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (div_sel == SEL_W'(i)) begin
        div_cur = act_all[i];
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_div_gen
//
// Scoreboard bench for clk_div_gen. A reference process keeps, per channel,
// the position within the current period, the active and pending divisor, and
// derives the expected outputs from those with plain integer arithmetic. Every
// clock it pushes the expected output set into a queue; a monitor pops one
// entry per cycle on the falling edge and compares it with the DUT.
// div_sel is 3 bits wide here so out-of-range channel addresses can be driven.
// -----------------------------------------------------------------------------
module tb_clk_div_gen;

  localparam int NCH   = 4;
  localparam int DIV_W = 20;
  localparam int SEL_W = 3;
  localparam logic [NCH*DIV_W-1:0] DEF = {20'd1000000, 20'd24, 20'd16, 20'd2};

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ch_en;
  logic             sync;
  logic             div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [DIV_W-1:0] div_val;
  logic             div_ack;
  logic             div_err;
  logic [DIV_W-1:0] div_cur;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   clk_out;

  clk_div_gen #(
    .NCH    (NCH),
    .DIV_W  (DIV_W),
    .SEL_W  (SEL_W),
    .DEF_DIV(DEF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ch_en  (ch_en),
    .sync   (sync),
    .div_wr (div_wr),
    .div_sel(div_sel),
    .div_val(div_val),
    .div_ack(div_ack),
    .div_err(div_err),
    .div_cur(div_cur),
    .tick   (tick),
    .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;
    logic             ack;
    logic             err;
    logic [DIV_W-1:0] cur;
  } want_t;

  want_t want_q[$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_run  [NCH];
  int m_pos  [NCH];
  int m_d    [NCH];
  int m_pend [NCH];
  int m_pv   [NCH];
  int m_ack, m_err;

  function automatic int def_div(input int i);
    logic [NCH*DIV_W-1:0] v;
    v = DEF;
    return int'(v[i*DIV_W +: DIV_W]);
  endfunction

  initial begin
    logic             s_rst, s_sync, s_wr;
    logic [NCH-1:0]   s_en;
    logic [SEL_W-1:0] s_sel;
    logic [DIV_W-1:0] s_val;
    bit               accept;
    want_t            w;
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_d[i] = def_div(i); m_pend[i] = 0; m_pv[i] = 0;
    end
    forever begin
      @(posedge clk);
      s_rst = rst; s_en = ch_en; s_sync = sync;
      s_wr = div_wr; s_sel = div_sel; s_val = div_val;
      accept = s_wr && (int'(s_sel) < NCH) && (s_val != 0);
      if (s_rst) begin
        for (int i = 0; i < NCH; i++) begin
          m_run[i] = 0; m_pos[i] = 0; m_d[i] = def_div(i); m_pv[i] = 0;
        end
        m_ack = 0; m_err = 0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (!s_en[i]) begin
            m_run[i] = 0; m_pos[i] = 0;
            if (m_pv[i] != 0) begin m_d[i] = m_pend[i]; m_pv[i] = 0; end
          end else if (m_run[i] == 0 || s_sync || m_pos[i] + 1 == m_d[i]) begin
            if (m_pv[i] != 0) begin m_d[i] = m_pend[i]; m_pv[i] = 0; end
            m_run[i] = 1; m_pos[i] = 0;
          end else begin
            m_pos[i] = m_pos[i] + 1;
          end
        end
        if (accept) begin
          m_pend[int'(s_sel)] = int'(s_val);
          m_pv[int'(s_sel)]   = 1;
        end
        m_ack = accept ? 1 : 0;
        m_err = (s_wr && !accept) ? 1 : 0;
      end
      // div_cur is combinational on div_sel, which the stimulus updates at +1.
      #2;
      for (int i = 0; i < NCH; i++) begin
        w.tick[i]    = (m_run[i] != 0) && (m_pos[i] == 0);
        w.clk_out[i] = (m_run[i] != 0) && (m_pos[i] < (m_d[i] + 1) / 2);
      end
      w.ack = (m_ack != 0);
      w.err = (m_err != 0);
      w.cur = (int'(div_sel) < NCH) ? DIV_W'(m_d[int'(div_sel)]) : '0;
      want_q.push_back(w);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cycle, got, exp_v);
    end
  endtask

  initial begin
    want_t w;
    forever begin
      @(negedge clk);
      cycle++;
      if (want_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        w = want_q.pop_front();
        chk("tick",    32'(tick),    32'(w.tick));
        chk("clk_out", 32'(clk_out), 32'(w.clk_out));
        chk("div_ack", 32'(div_ack), 32'(w.ack));
        chk("div_err", 32'(div_err), 32'(w.err));
        chk("div_cur", 32'(div_cur), 32'(w.cur));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
    div_wr = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input int sel, input int val);
    cyc();
    div_wr  = 1'b1;
    div_sel = SEL_W'(sel);
    div_val = DIV_W'(val);
    $display("write sel=%0d val=%0d", sel, val);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    rst = 1'b1; ch_en = '0; sync = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0;
    idle(3);
    // Reset release with defaults, all channels enabled.
    rst = 1'b0; ch_en = 4'b1111; div_sel = 3'd1;
    idle(50);
    // ch1 write mid-period, then observe the boundary switch to 5.
    idle(3);
    wr(1, 5);
    idle(40);
    // Invalid writes: zero divisor and out-of-range channels.
    wr(2, 0);
    wr(4, 7);
    wr(7, 3);
    div_sel = 3'd5;
    idle(5);
    // Last write wins on ch2, then a D=1 channel.
    wr(2, 7);
    wr(2, 9);
    div_sel = 3'd2;
    idle(60);
    wr(0, 1);
    idle(10);
    wr(0, 3);
    idle(7);
    // sync with ch2 disabled.
    ch_en = 4'b1011;
    idle(4);
    sync = 1'b1;
    idle(20);
    ch_en = 4'b1111;
    // Drop ch1 mid-period, re-enable 10 cycles later.
    idle(6);
    ch_en[1] = 1'b0;
    idle(10);
    ch_en[1] = 1'b1;
    idle(20);
    // Reset mid-period with a pending write.
    wr(1, 3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    div_sel = 3'd1;
    idle(40);
    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      cyc();
      rst  = ($urandom_range(499) == 0);
      sync = ($urandom_range(49) == 0);
      if ($urandom_range(39) == 0) begin
        b = $urandom_range(NCH - 1);
        ch_en[b] = ~ch_en[b];
      end
      div_sel = SEL_W'($urandom_range(7));
      if ($urandom_range(3) == 0) begin
        div_wr  = 1'b1;
        div_val = ($urandom_range(9) == 0) ? DIV_W'($urandom_range(400)) : DIV_W'($urandom_range(12));
        $display("write sel=%0d val=%0d", div_sel, div_val);
      end
    end
    idle(5);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
